// File: rtl/keypad_pkg.sv
// Shared key codes, strobe/row constants and the
// keypad map for the 4x4 matrix scanner.
package keypad_pkg;

    localparam logic [3:0] KEY_0      = 4'd0;
    localparam logic [3:0] KEY_1      = 4'd1;
    localparam logic [3:0] KEY_2      = 4'd2;
    localparam logic [3:0] KEY_3      = 4'd3;
    localparam logic [3:0] KEY_4      = 4'd4;
    localparam logic [3:0] KEY_5      = 4'd5;
    localparam logic [3:0] KEY_6      = 4'd6;
    localparam logic [3:0] KEY_7      = 4'd7;
    localparam logic [3:0] KEY_8      = 4'd8;
    localparam logic [3:0] KEY_9      = 4'd9;
    localparam logic [3:0] KEY_BKSP   = 4'd10;
    localparam logic [3:0] KEY_ENTER  = 4'd11;
    localparam logic [3:0] KEY_PAUSE  = 4'd12;
    localparam logic [3:0] KEY_SWITCH = 4'd13;
    localparam logic [3:0] KEY_NONE   = 4'd14;

    localparam logic [3:0] COL_1 = 4'b0111;
    localparam logic [3:0] COL_2 = 4'b1011;
    localparam logic [3:0] COL_3 = 4'b1101;
    localparam logic [3:0] COL_4 = 4'b1110;

    localparam logic [3:0] ROW_1 = 4'b0111;
    localparam logic [3:0] ROW_2 = 4'b1011;
    localparam logic [3:0] ROW_3 = 4'b1101;
    localparam logic [3:0] ROW_4 = 4'b1110;

    // Element [c] is the key in column c of that row; C and D read as NONE.
    localparam logic [3:0][3:0] MAP_R1 = {KEY_PAUSE, KEY_3, KEY_2, KEY_1};
    localparam logic [3:0][3:0] MAP_R2 = {KEY_SWITCH, KEY_6, KEY_5, KEY_4};
    localparam logic [3:0][3:0] MAP_R3 = {KEY_NONE, KEY_9, KEY_8, KEY_7};
    localparam logic [3:0][3:0] MAP_R4 = {KEY_NONE, KEY_ENTER, KEY_0, KEY_BKSP};

    typedef enum logic [1:0] {
        DB_IDLE,
        DB_CAND,
        DB_PRESSED
    } db_state_e;

    function automatic logic [3:0] key_map(
        input logic [1:0] col,
        input logic [3:0] row
    );
        logic [3:0] code;
        code = KEY_NONE;
        case (row)
            ROW_1:   code = MAP_R1[col];
            ROW_2:   code = MAP_R2[col];
            ROW_3:   code = MAP_R3[col];
            ROW_4:   code = MAP_R4[col];
            default: code = KEY_NONE;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/keypad_scanner_debouncer.sv
// Two-scan confirmation FSM: a key must appear in two
// consecutive scans and needs a NO_KEY scan to re-arm.
module key_debouncer
    import keypad_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       scan_done,
    input  logic [3:0] scan_key,
    output logic       key_valid,
    output logic [3:0] key_code
);

    db_state_e  state_q, state_d;
    logic [3:0] cand_q, cand_d;
    logic       valid_q, valid_d;
    logic [3:0] code_q, code_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= DB_IDLE;
            cand_q  <= KEY_NONE;
            valid_q <= 1'b0;
            code_q  <= KEY_NONE;
        end else begin
            state_q <= state_d;
            cand_q  <= cand_d;
            valid_q <= valid_d;
            code_q  <= code_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cand_d  = cand_q;
        if (scan_done) begin
            unique case (state_q)
                DB_IDLE: begin
                    if (scan_key != KEY_NONE) begin
                        state_d = DB_CAND;
                        cand_d  = scan_key;
                    end
                end
                DB_CAND: begin
                    if (scan_key == KEY_NONE) begin
                        state_d = DB_IDLE;
                    end else if (scan_key == cand_q) begin
                        state_d = DB_PRESSED;
                    end else begin
                        cand_d = scan_key;
                    end
                end
                DB_PRESSED: begin
                    if (scan_key == KEY_NONE) begin
                        state_d = DB_IDLE;
                    end
                end
                default: state_d = DB_IDLE;
            endcase
        end
    end

    always_comb begin
        valid_d = scan_done
               && (state_q == DB_CAND)
               && (scan_key == cand_q)
               && (scan_key != KEY_NONE);
        code_d  = valid_d ? cand_q : code_q;
    end

    assign key_valid = valid_q;
    assign key_code  = code_q;

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 keypad column strobe, row synchronizer and per-scan
// accumulator feeding the debounce FSM.
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int unsigned SCAN_TICKS = 62501
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] row_in,
    output logic [3:0] col_out,
    output logic       key_valid,
    output logic [3:0] key_code
);

    localparam int unsigned TW = $clog2(SCAN_TICKS);
    localparam logic [TW-1:0] LAST = TW'(SCAN_TICKS - 1);

    logic [3:0]    sync1_q, sync2_q;
    logic [TW-1:0] tick_q, tick_d;
    logic [1:0]    col_q, col_d;
    logic [1:0]    acc_cnt_q, acc_cnt_d;
    logic [3:0]    acc_key_q, acc_key_d;

    logic          sample;
    logic [2:0]    hit_n;
    logic [1:0]    col_cnt;
    logic [3:0]    col_key;
    logic [1:0]    base_cnt;
    logic [3:0]    base_key;
    logic [2:0]    sum;
    logic [1:0]    sat_cnt;
    logic [3:0]    new_key;
    logic          scan_done;
    logic [3:0]    scan_key;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q   <= 4'hf;
            sync2_q   <= 4'hf;
            tick_q    <= '0;
            col_q     <= 2'd0;
            acc_cnt_q <= 2'd0;
            acc_key_q <= KEY_NONE;
        end else begin
            sync1_q   <= row_in;
            sync2_q   <= sync1_q;
            tick_q    <= tick_d;
            col_q     <= col_d;
            acc_cnt_q <= acc_cnt_d;
            acc_key_q <= acc_key_d;
        end
    end

    // Press count saturates at 2: anything above one key is a ghost.
    always_comb begin
        sample   = (tick_q == LAST);
        tick_d   = sample ? '0 : tick_q + TW'(1);
        col_d    = sample ? col_q + 2'd1 : col_q;
        hit_n    = 3'($countones(~sync2_q));
        col_cnt  = (hit_n > 3'd1) ? 2'd2 : hit_n[1:0];
        col_key  = key_map(col_q, sync2_q);
        base_cnt = (col_q == 2'd0) ? 2'd0 : acc_cnt_q;
        base_key = (col_q == 2'd0) ? KEY_NONE : acc_key_q;
        sum      = {1'b0, base_cnt} + {1'b0, col_cnt};
        sat_cnt  = (sum > 3'd1) ? 2'd2 : sum[1:0];
        new_key  = (col_cnt != 2'd0) ? col_key : base_key;
        acc_cnt_d = sample ? sat_cnt : acc_cnt_q;
        acc_key_d = sample ? new_key : acc_key_q;
        scan_done = sample && (col_q == 2'd3);
        scan_key  = (sat_cnt == 2'd1) ? new_key : KEY_NONE;
    end

    always_comb begin
        col_out = COL_1;
        unique case (col_q)
            2'd0: col_out = COL_1;
            2'd1: col_out = COL_2;
            2'd2: col_out = COL_3;
            2'd3: col_out = COL_4;
            default: col_out = COL_1;
        endcase
    end

    key_debouncer u_debouncer (
        .clk       (clk),
        .rst_n     (rst_n),
        .scan_done (scan_done),
        .scan_key  (scan_key),
        .key_valid (key_valid),
        .key_code  (key_code)
    );

endmodule

// File: tb/tb_keypad_scanner.sv
// Randomized bench: a physical keypad model drives row_in
// and a scan-level reference predicts accepted keys.
module tb_keypad_scanner;

    localparam int ST = 8;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] row_in;
    logic [3:0] col_out;
    logic       key_valid;
    logic [3:0] key_code;

    always #5 clk = ~clk;

    keypad_scanner #(.SCAN_TICKS(ST)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .row_in    (row_in),
        .col_out   (col_out),
        .key_valid (key_valid),
        .key_code  (key_code)
    );

    // Bit r*4+c of keys = key at row r (ROW_1=0), column c (COL_1=0) held.
    logic [15:0] keys = '0;

    always_comb begin
        row_in = 4'hf;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (keys[r*4+c] && col_out[3-c] == 1'b0)
                    row_in[3-r] = 1'b0;
    end

    int key_tab [16] = '{1, 2, 3, 12, 4, 5, 6, 13,
                         7, 8, 9, 14, 10, 0, 11, 14};

    int n_checks = 0;
    int n_pass = 0;
    int obs_q[$];
    int exp_q[$];
    int bad_timing;
    int m_prev;
    bit m_armed;

    function automatic logic [15:0] kb(input int r, input int c);
        return 16'b1 << (r*4 + c);
    endfunction

    function automatic int scan_result(input logic [15:0] k);
        int idx;
        idx = 0;
        if ($countones(k) != 1) return 14;
        for (int i = 0; i < 16; i++)
            if (k[i]) idx = i;
        return key_tab[idx];
    endfunction

    task automatic model_reset();
        m_prev = 14;
        m_armed = 1'b1;
        obs_q.delete();
        exp_q.delete();
        bad_timing = 0;
    endtask

    // Starts at the first cycle of COL_1, ends at the next scan's first cycle.
    task automatic run_scan(input logic [15:0] k);
        int res;
        keys = k;
        for (int i = 0; i < 4*ST; i++) begin
            if (key_valid === 1'b1) begin
                obs_q.push_back(int'(key_code));
                if (i != 0) bad_timing++;
            end
            @(negedge clk);
        end
        res = scan_result(k);
        if (res != 14) begin
            if (m_armed && res == m_prev) begin
                exp_q.push_back(res);
                m_armed = 1'b0;
            end
        end else begin
            m_armed = 1'b1;
        end
        m_prev = res;
    endtask

    task automatic sync_to_scan();
        int n;
        n = 0;
        while (col_out !== 4'b1110 && n < 100) begin
            @(negedge clk);
            n++;
        end
        while (col_out !== 4'b0111 && n < 100) begin
            @(negedge clk);
            n++;
        end
        n_checks++;
        if (n >= 100) $display("FAIL sync: col_out=%b never wrapped", col_out);
        else n_pass++;
    endtask

    task automatic test_reset();
        logic [3:0] order [4];
        order = '{4'b0111, 4'b1011, 4'b1101, 4'b1110};
        rst_n = 1'b0;
        keys = '0;
        repeat (3) @(negedge clk);
        n_checks++;
        if (col_out !== 4'b0111) $display("FAIL rst col_out: got %b want 0111", col_out);
        else n_pass++;
        n_checks++;
        if (key_valid !== 1'b0) $display("FAIL rst key_valid: got %b want 0", key_valid);
        else n_pass++;
        n_checks++;
        if (key_code !== 4'd14) $display("FAIL rst key_code: got %0d want 14", key_code);
        else n_pass++;
        rst_n = 1'b1;
        for (int n = 0; n < 40; n++) begin
            n_checks++;
            if (col_out !== order[(n/ST)%4])
                $display("FAIL col_seq[%0d]: got %b want %b", n, col_out, order[(n/ST)%4]);
            else n_pass++;
            @(negedge clk);
        end
        model_reset();
        sync_to_scan();
    endtask

    task automatic test_single_press();
        model_reset();
        run_scan('0);
        repeat (7) run_scan(kb(1, 2));
        repeat (2) run_scan('0);
        n_checks++;
        if (obs_q.size() != 1 || obs_q[0] != 6 || bad_timing != 0)
            $display("FAIL single: got %0d pulses (bad_timing %0d) want 1 pulse code 6",
                     obs_q.size(), bad_timing);
        else n_pass++;
        n_checks++;
        if (obs_q.size() != exp_q.size())
            $display("FAIL single model: got %0d pulses want %0d", obs_q.size(), exp_q.size());
        else n_pass++;
        n_checks++;
        if (key_code !== 4'd6) $display("FAIL single hold: key_code %0d want 6", key_code);
        else n_pass++;
    endtask

    task automatic test_sweep();
        int pos [16];
        int mask;
        model_reset();
        for (int i = 0; i < 16; i++) pos[i] = i;
        for (int i = 15; i > 0; i--) begin
            int j, t;
            j = $urandom_range(0, i);
            t = pos[i]; pos[i] = pos[j]; pos[j] = t;
        end
        run_scan('0);
        for (int i = 0; i < 16; i++) begin
            repeat (2) run_scan(16'b1 << pos[i]);
            repeat (1 + $urandom_range(0, 1)) run_scan('0);
        end
        mask = 0;
        foreach (obs_q[i]) mask |= (1 << obs_q[i]);
        n_checks++;
        if (obs_q.size() != 14 || mask != 32'h3fff || bad_timing != 0)
            $display("FAIL sweep: got %0d pulses mask %h want 14 mask 3fff",
                     obs_q.size(), mask);
        else n_pass++;
        n_checks++;
        if (obs_q.size() != exp_q.size())
            $display("FAIL sweep model: got %0d pulses want %0d", obs_q.size(), exp_q.size());
        else n_pass++;
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            n_checks++;
            if (obs_q[i] != exp_q[i])
                $display("FAIL sweep code[%0d]: got %0d want %0d", i, obs_q[i], exp_q[i]);
            else n_pass++;
        end
    endtask

    task automatic test_ghost_bounce();
        int a, b;
        model_reset();
        a = $urandom_range(0, 15);
        b = (a + 1 + $urandom_range(0, 14)) % 16;
        run_scan('0);
        repeat (3) run_scan(kb(0, 0) | kb(0, 1));
        run_scan('0);
        repeat (3) run_scan((16'b1 << a) | (16'b1 << b));
        run_scan('0);
        run_scan(kb(1, 1));
        run_scan('0);
        run_scan(kb(1, 1));
        run_scan(kb(2, 1));
        run_scan(kb(2, 1));
        repeat (2) run_scan('0);
        n_checks++;
        if (obs_q.size() != 1 || obs_q[0] != 8 || bad_timing != 0)
            $display("FAIL ghost: got %0d pulses want 1 pulse code 8", obs_q.size());
        else n_pass++;
        n_checks++;
        if (obs_q.size() != exp_q.size())
            $display("FAIL ghost model: got %0d pulses want %0d", obs_q.size(), exp_q.size());
        else n_pass++;
    endtask

    task automatic test_repeat();
        model_reset();
        run_scan('0);
        repeat (2) run_scan(kb(3, 1));
        run_scan('0);
        repeat (2) run_scan(kb(3, 1));
        repeat (2) run_scan('0);
        repeat (4) run_scan(kb(3, 1));
        repeat (2) run_scan('0);
        n_checks++;
        if (obs_q.size() != 3 || bad_timing != 0)
            $display("FAIL repeat: got %0d pulses want 3", obs_q.size());
        else n_pass++;
        foreach (obs_q[i]) begin
            n_checks++;
            if (obs_q[i] != 0) $display("FAIL repeat code[%0d]: got %0d want 0", i, obs_q[i]);
            else n_pass++;
        end
    endtask

    task automatic test_random();
        int pool [3];
        model_reset();
        foreach (pool[i]) pool[i] = $urandom_range(0, 15);
        run_scan('0);
        for (int s = 0; s < 60; s++) begin
            int r;
            r = $urandom_range(0, 9);
            if (r < 3) run_scan('0);
            else if (r < 9) run_scan(16'b1 << pool[$urandom_range(0, 2)]);
            else run_scan((16'b1 << $urandom_range(0, 15)) | (16'b1 << $urandom_range(0, 15)));
        end
        repeat (2) run_scan('0);
        n_checks++;
        if (obs_q.size() != exp_q.size() || bad_timing != 0)
            $display("FAIL random: got %0d pulses (bad_timing %0d) want %0d",
                     obs_q.size(), bad_timing, exp_q.size());
        else n_pass++;
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            n_checks++;
            if (obs_q[i] != exp_q[i])
                $display("FAIL random code[%0d]: got %0d want %0d", i, obs_q[i], exp_q[i]);
            else n_pass++;
        end
    endtask

    task automatic test_reset_mid();
        model_reset();
        run_scan('0);
        run_scan(kb(2, 2));
        keys = kb(2, 2);
        repeat (2*ST) @(negedge clk);
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (col_out !== 4'b0111 || key_valid !== 1'b0 || key_code !== 4'd14)
            $display("FAIL mid_rst: col %b valid %b code %0d want 0111 0 14",
                     col_out, key_valid, key_code);
        else n_pass++;
        repeat (4) @(negedge clk);
        n_checks++;
        if (key_valid !== 1'b0 || obs_q.size() != 0)
            $display("FAIL mid_rst pulse: valid %b pulses %0d want 0 0", key_valid, obs_q.size());
        else n_pass++;
        keys = '0;
        rst_n = 1'b1;
        model_reset();
        sync_to_scan();
        run_scan('0);
        repeat (2) run_scan(kb(2, 2));
        repeat (2) run_scan('0);
        n_checks++;
        if (obs_q.size() != 1 || obs_q[0] != 9 || bad_timing != 0)
            $display("FAIL mid_rst repress: got %0d pulses want 1 pulse code 9", obs_q.size());
        else n_pass++;
    endtask

    initial begin
        model_reset();
        test_reset();
        test_single_press();
        test_sweep();
        test_ghost_bounce();
        test_repeat();
        test_random();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
